instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front stage of the five-stage MIPS pipeline and the producer side of the IF/ID interface that the decode stage consumes. Holds the program counter, issues word fetches to instruction memory over a request/ready handshake, and drives the IF/ID pipeline register (PC+4 and instruction word). It obeys decode's `pcWrite`/`ifIdWrite` stall controls and `branch`/`branchProgramCounter` redirect, and discards wrong-path fetches that are still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetched instruction.
- `clk  in  1`: clock; all state updates on the falling edge, matching the pipeline-register edge.
- `reset  in  1`: reset; **synchronous and active-high**, sampled at the falling edge of `clk`.
- `pcWrite  in  1`: 0 freezes the PC (load-use stall from decode).
- `ifIdWrite  in  1`: 0 freezes the IF/ID register.
- `branch  in  1`: taken-branch redirect from decode; already gated by decode's flush and bubble logic.
- `branchProgramCounter  in  32`: redirect target, byte address.
- `imemRequest  out  1`: fetch request valid.
- `imemAddress  out  32`: fetch byte address; stable while `imemRequest` is high and not yet acknowledged.
- `imemReady  in  1`: fetch completes at the edge where `imemRequest & imemReady`.
- `imemData  in  32`: instruction word; valid when `imemReady` is high.
- `programCounterOut  out  32`: IF/ID PC, equal to fetch address + 4.
- `instruction  out  32`: IF/ID instruction word.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `requestAddress`: drives `imemAddress`.
  - `holdBuffer`: 32-bit instruction store.
  - `state`.
- NOP bubble = 32'h0000_0000.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. `branchProgramCounter` is used as given; its low two bits are not checked.
- Priority: `reset` > `branch` > stall (`pcWrite`/`ifIdWrite`) > normal advance.
- FETCH state (`imemRequest`=1, `requestAddress`=`pc`):
  - Fetch completes and `branch`=1: IF/ID <= fetched word (decode squashes it). `pc` <= target. Stay in FETCH.
  - Fetch completes, `ifIdWrite`=1, `pcWrite`=1: IF/ID <= {`pc`+4, `imemData`}. `pc` <= `pc`+4.
  - Fetch completes, `ifIdWrite`=0: `holdBuffer` <= `imemData`. Go to HOLD. `pc` unchanged.
  - No completion and `branch`=1: IF/ID <= NOP. `pc` <= target. Go to DISCARD.
  - No completion otherwise: IF/ID <= NOP if `ifIdWrite`=1, else IF/ID holds.
- HOLD state (`imemRequest`=0):
  - `branch`=1: drop `holdBuffer`. `pc` <= target. Go to FETCH.
  - `ifIdWrite`=1 and `pcWrite`=1: IF/ID <= {`pc`+4, `holdBuffer`}. `pc` <= `pc`+4. Go to FETCH.
  - Otherwise: hold.
- DISCARD state (`imemRequest`=1, `requestAddress` keeps the stale address):
  - On completion: drop `imemData`. Go to FETCH.
  - `branch`=1 while in DISCARD: updates `pc`; state stays DISCARD.
  - IF/ID <= NOP each cycle while `ifIdWrite`=1.
- `pcWrite`=1 with `ifIdWrite`=0 is treated as a full stall.

## Timing
- Reset values:
  - `pc` = `requestAddress` = `imemAddress` = `RESET_PC`.
  - `programCounterOut` = `RESET_PC`.
  - `instruction` = NOP.
  - `holdBuffer` = 0.
  - `state` = FETCH.
  - `imemRequest` = 0 while `reset` is high; 1 from the first cycle after it is released.
- Reset mid-transaction: an outstanding request is abandoned and a response in the reset cycle is ignored. The memory must tolerate a dropped request.
- Zero-wait memory (`imemReady` tied 1): one instruction per cycle. IF/ID updates at the same falling edge the fetch completes (1-cycle latency).
- Redirect: the target is requested in the cycle after `branch` is sampled. Exception: DISCARD, where it is requested after the stale response returns.
- `imemRequest`/`imemAddress` are registered outputs; they never change combinationally with `branch`.

## Structure
- Shared package holds:
  - `NOP_INSTRUCTION` = 32'h0.
  - `INSTRUCTION_BYTES` = 4.
  - The fetch-state enum: FETCH, HOLD, DISCARD.
- One sub-module, `program_counter`: next-PC mux (hold / +4 / branch target) plus `pc` register with synchronous reset to `RESET_PC`.
- FSM, hold buffer, and IF/ID register live in `instruction_fetch`.

## Test plan
- Reset, `RESET_PC`=32'h40, `imemReady`=1, memory returns address as data → IF/ID shows {32'h44,32'h40}, {32'h48,32'h44} on consecutive edges.
- Two-cycle-wait memory → NOP, NOP, then {`pc`+4, word}; `imemAddress` stable throughout.
- `pcWrite`=`ifIdWrite`=0 for 1 cycle while a fetch of 32'h10 completes → IF/ID unchanged, HOLD; next cycle IF/ID = {32'h14, word@10}, with no re-request of 32'h10.
- `branch`=1 to 32'h200 during an outstanding 3-wait fetch of 32'h20 → IF/ID NOP, response for 32'h20 dropped, next request is 32'h200.
- `pc`=32'hFFFF_FFFC, zero-wait → `programCounterOut`=0; next `imemAddress`=0.
- `reset` asserted during a wait cycle → `imemRequest`=0, outputs at reset values, first post-reset request at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and fetch-state encoding for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTRUCTION   = 32'h0000_0000;
  localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetchState_e;

endpackage

// File: rtl/program_counter.sv
// Program counter: next-PC select (hold / +4 / redirect) and the PC register.
// The PC updates on the falling edge, like the rest of the fetch stage.
module program_counter
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] pcNext
);

  // Sequential increment wraps modulo 2^32; redirect wins over advance.
  always_comb begin
    pcPlus4 = pc + INSTRUCTION_BYTES;
    pcNext  = pc;
    if (redirect) begin
      pcNext = target;
    end else if (advance) begin
      pcNext = pcPlus4;
    end
  end

  // PC register with synchronous reset to the boot address.
  always_ff @(negedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pcNext;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, request/ready fetch handshake, hold buffer for
// words that arrive while decode stalls, wrong-path discard, IF/ID register.
//
// state   | meaning
// FETCH   | request outstanding at pc (idle only in the first cycle after reset)
// HOLD    | fetched word parked in holdBuffer while IF/ID is frozen, no request
// DISCARD | stale request still in flight after a redirect; its word is dropped
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcWrite,
  input  logic        ifIdWrite,
  input  logic        branch,
  input  logic [31:0] branchProgramCounter,
  output logic        imemRequest,
  output logic [31:0] imemAddress,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] programCounterOut,
  output logic [31:0] instruction
);

  fetchState_e state;
  fetchState_e nextState;

  logic        requestValid;
  logic [31:0] requestAddress;
  logic [31:0] holdBuffer;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdInstruction;

  logic [31:0] ifIdPcNext;
  logic [31:0] ifIdInstructionNext;
  logic        loadHold;
  logic        advance;
  logic        redirect;
  logic        completes;

  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] pcNext;

  program_counter #(
    .RESET_PC(RESET_PC)
  ) programCounter (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .redirect(redirect),
    .target  (branchProgramCounter),
    .pc      (pc),
    .pcPlus4 (pcPlus4),
    .pcNext  (pcNext)
  );

  assign completes         = requestValid & imemReady;
  assign imemRequest       = requestValid;
  assign imemAddress       = requestAddress;
  assign programCounterOut = ifIdPc;
  assign instruction       = ifIdInstruction;

  // Next-state, PC control and IF/ID next value; branch outranks stalls.
  always_comb begin
    nextState           = state;
    advance             = 1'b0;
    redirect            = 1'b0;
    loadHold            = 1'b0;
    ifIdPcNext          = ifIdPc;
    ifIdInstructionNext = ifIdInstruction;
    case (state)
      FETCH: begin
        if (completes) begin
          if (branch) begin
            // Word goes to IF/ID anyway; decode squashes it.
            ifIdPcNext          = pcPlus4;
            ifIdInstructionNext = imemData;
            redirect            = 1'b1;
          end else if (ifIdWrite && pcWrite) begin
            ifIdPcNext          = pcPlus4;
            ifIdInstructionNext = imemData;
            advance             = 1'b1;
          end else begin
            loadHold  = 1'b1;
            nextState = HOLD;
          end
        end else if (branch) begin
          ifIdInstructionNext = NOP_INSTRUCTION;
          redirect            = 1'b1;
          // Only a request actually in flight needs its response dropped.
          if (requestValid) begin
            nextState = DISCARD;
          end
        end else if (ifIdWrite) begin
          ifIdInstructionNext = NOP_INSTRUCTION;
        end
      end
      HOLD: begin
        if (branch) begin
          redirect  = 1'b1;
          nextState = FETCH;
        end else if (ifIdWrite && pcWrite) begin
          ifIdPcNext          = pcPlus4;
          ifIdInstructionNext = holdBuffer;
          advance             = 1'b1;
          nextState           = FETCH;
        end
      end
      DISCARD: begin
        if (branch) begin
          redirect = 1'b1;
        end
        if (ifIdWrite) begin
          ifIdInstructionNext = NOP_INSTRUCTION;
        end
        if (completes) begin
          nextState = FETCH;
        end
      end
      default: begin
        nextState = FETCH;
      end
    endcase
  end

  // State, request, hold buffer and IF/ID registers on the pipeline edge.
  always_ff @(negedge clk) begin
    if (reset) begin
      state           <= FETCH;
      requestValid    <= 1'b0;
      requestAddress  <= RESET_PC;
      holdBuffer      <= NOP_INSTRUCTION;
      ifIdPc          <= RESET_PC;
      ifIdInstruction <= NOP_INSTRUCTION;
    end else begin
      state        <= nextState;
      requestValid <= (nextState != HOLD);
      // DISCARD keeps presenting the stale address until it is acknowledged.
      if (nextState == FETCH) begin
        requestAddress <= pcNext;
      end
      if (loadHold) begin
        holdBuffer <= imemData;
      end
      ifIdPc          <= ifIdPcNext;
      ifIdInstruction <= ifIdInstructionNext;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// random stalls, redirects, resets and memory wait states, compared against
// a transaction-level model of the fetch stream.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcWrite;
  logic        ifIdWrite;
  logic        branch;
  logic [31:0] branchProgramCounter;
  logic        imemRequest;
  logic [31:0] imemAddress;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] programCounterOut;
  logic [31:0] instruction;

  int total = 0;
  int bad   = 0;

  // Reference model: next instruction owed to decode, parked word, and
  // whether the request in flight is on the wrong path.
  logic [31:0] expPcOut;
  logic [31:0] expInstr;
  logic [31:0] nextDeliver;
  logic [31:0] staleAddr;
  logic [31:0] heldAddr;
  logic [31:0] heldWord;
  bit          expReq;
  bit          held;
  bit          wrongPath;

  // Memory responder.
  int          waitN       = 0;
  int          elapsed     = 0;
  bit          randomWaits = 1'b0;
  logic [31:0] memKey      = 32'h0;

  instruction_fetch #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pcWrite             (pcWrite),
    .ifIdWrite           (ifIdWrite),
    .branch              (branch),
    .branchProgramCounter(branchProgramCounter),
    .imemRequest         (imemRequest),
    .imemAddress         (imemAddress),
    .imemReady           (imemReady),
    .imemData            (imemData),
    .programCounterOut   (programCounterOut),
    .instruction         (instruction)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ memKey;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, "_req"}, 32'(imemRequest), 32'(expReq));
    if (expReq) begin
      chk({tag, "_addr"}, imemAddress, wrongPath ? staleAddr : nextDeliver);
    end
    chk({tag, "_pcOut"}, programCounterOut, expPcOut);
    chk({tag, "_instr"}, instruction, expInstr);
  endtask

  // One falling edge: drive inputs, advance the model, then check outputs.
  task automatic step(input bit rst, input bit br, input logic [31:0] tgt,
                      input bit pcW, input bit ifW, input string tag);
    bit          rdy;
    bit          c;
    logic [31:0] addr;
    logic [31:0] word;
    if (imemRequest === 1'b1) rdy = (elapsed >= waitN);
    else                      rdy = ($urandom_range(0, 1) == 1);
    reset                = rst;
    branch               = br;
    branchProgramCounter = tgt;
    pcWrite              = pcW;
    ifIdWrite            = ifW;
    imemReady            = rdy;
    imemData             = rdy ? memWord(imemAddress) : $urandom;

    if (rst) begin
      elapsed = 0;
    end else if (imemRequest === 1'b1 && rdy) begin
      elapsed = 0;
      if (randomWaits) waitN = $urandom_range(0, 3);
    end else if (imemRequest === 1'b1) begin
      elapsed++;
    end

    c = expReq & rdy;
    if (rst) begin
      nextDeliver = RST_PC;
      expPcOut    = RST_PC;
      expInstr    = 32'h0;
      held        = 1'b0;
      wrongPath   = 1'b0;
      expReq      = 1'b0;
    end else begin
      if (held) begin
        if (br) begin
          held        = 1'b0;
          nextDeliver = tgt;
        end else if (pcW && ifW) begin
          expPcOut    = heldAddr + 32'd4;
          expInstr    = heldWord;
          held        = 1'b0;
          nextDeliver = heldAddr + 32'd4;
        end
      end else if (c) begin
        addr = wrongPath ? staleAddr : nextDeliver;
        word = memWord(addr);
        if (wrongPath) begin
          wrongPath = 1'b0;
          if (ifW) expInstr = 32'h0;
          if (br) nextDeliver = tgt;
        end else if (br) begin
          expPcOut    = addr + 32'd4;
          expInstr    = word;
          nextDeliver = tgt;
        end else if (pcW && ifW) begin
          expPcOut    = addr + 32'd4;
          expInstr    = word;
          nextDeliver = addr + 32'd4;
        end else begin
          held     = 1'b1;
          heldAddr = addr;
          heldWord = word;
        end
      end else if (expReq) begin
        if (wrongPath) begin
          if (ifW) expInstr = 32'h0;
          if (br) nextDeliver = tgt;
        end else if (br) begin
          expInstr    = 32'h0;
          wrongPath   = 1'b1;
          staleAddr   = nextDeliver;
          nextDeliver = tgt;
        end else if (ifW) begin
          expInstr = 32'h0;
        end
      end else begin
        if (br) begin
          expInstr    = 32'h0;
          nextDeliver = tgt;
        end else if (ifW) begin
          expInstr = 32'h0;
        end
      end
      expReq = !held;
    end

    @(negedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    bit          r;
    bit          b;
    bit          pw;
    bit          iw;
    int          s;
    logic [31:0] t;

    reset = 1'b1; pcWrite = 1'b1; ifIdWrite = 1'b1; branch = 1'b0;
    branchProgramCounter = 32'h0; imemReady = 1'b0; imemData = 32'h0;
    expPcOut = 32'h0; expInstr = 32'h0; nextDeliver = 32'h0; staleAddr = 32'h0;
    heldAddr = 32'h0; heldWord = 32'h0; expReq = 1'b0; held = 1'b0; wrongPath = 1'b0;

    // Reset and zero-wait streaming, memory returns the address as data.
    step(1, 0, 0, 1, 1, "rst0");
    step(1, 0, 0, 1, 1, "rst1");
    chk("rst_req", 32'(imemRequest), 32'h0);
    chk("rst_addr", imemAddress, 32'h40);
    chk("rst_pcOut", programCounterOut, 32'h40);
    chk("rst_instr", instruction, 32'h0);
    step(0, 0, 0, 1, 1, "release");
    chk("release_req", 32'(imemRequest), 32'h1);
    step(0, 0, 0, 1, 1, "zw0");
    chk("zw0_pair", programCounterOut ^ instruction, 32'h44 ^ 32'h40);
    chk("zw0_pc", programCounterOut, 32'h44);
    step(0, 0, 0, 1, 1, "zw1");
    chk("zw1_pc", programCounterOut, 32'h48);
    chk("zw1_instr", instruction, 32'h44);

    // Two-wait memory: two bubbles, then the word; address held steady.
    memKey = 32'hC0DE_0000;
    waitN  = 2;
    step(0, 0, 0, 1, 1, "w2a");
    step(0, 0, 0, 1, 1, "w2b");
    chk("w2_addr_stable", imemAddress, 32'h48);
    step(0, 0, 0, 1, 1, "w2c");
    chk("w2_instr", instruction, 32'h48 ^ 32'hC0DE_0000);

    // Stall while the fetch of 0x10 completes: park, then deliver, no re-fetch.
    waitN = 0;
    step(0, 1, 32'h10, 1, 1, "br10");
    step(0, 0, 0, 0, 0, "stall10");
    chk("hold_req", 32'(imemRequest), 32'h0);
    chk("hold_pcOut", programCounterOut, 32'h50);
    step(0, 0, 0, 1, 1, "unhold");
    chk("unhold_pc", programCounterOut, 32'h14);
    chk("unhold_instr", instruction, 32'h10 ^ 32'hC0DE_0000);
    chk("unhold_addr", imemAddress, 32'h14);

    // Redirect to 0x200 during a three-wait fetch of 0x20.
    step(0, 1, 32'h20, 1, 1, "br20");
    waitN = 3;
    step(0, 0, 0, 1, 1, "w3a");
    step(0, 1, 32'h200, 1, 1, "brDuring");
    chk("discard_instr", instruction, 32'h0);
    chk("discard_addr", imemAddress, 32'h20);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 1, "discard");
    chk("redirect_addr", imemAddress, 32'h200);
    waitN = 0;
    step(0, 0, 0, 1, 1, "after200");
    chk("after200_pc", programCounterOut, 32'h204);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 1, 1, "brTop");
    step(0, 0, 0, 1, 1, "wrap");
    chk("wrap_pcOut", programCounterOut, 32'h0);
    chk("wrap_addr", imemAddress, 32'h0);

    // Reset in the middle of a wait.
    waitN = 3;
    step(0, 0, 0, 1, 1, "preRst");
    step(1, 0, 0, 1, 1, "midRst");
    chk("midRst_req", 32'(imemRequest), 32'h0);
    chk("midRst_pcOut", programCounterOut, 32'h40);
    waitN = 0;
    step(0, 0, 0, 1, 1, "postRst");
    chk("postRst_addr", imemAddress, 32'h40);

    // Random traffic.
    randomWaits = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = $urandom_range(0, 1023) << 2;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8 + (t & 32'h4);
      s = $urandom_range(0, 9);
      if (s < 2)       begin pw = 1'b0; iw = 1'b0; end
      else if (s == 2) begin pw = 1'b1; iw = 1'b0; end
      else             begin pw = 1'b1; iw = 1'b1; end
      step(r, b, t, pw, iw, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
